reg_write_decoder: RTL and testbench

Registered, parametrised one-hot write-enable decoder for the register file write port. It converts an `SEL_W`-bit register index into a `2**SEL_W`-bit one-hot write strobe, optionally masking index 0 as a hardwired-zero register. It also provides a self-timed clear sweep that asserts every strobe in turn, one per cycle, so the register file can be initialised without datapath involvement. It sits between the writeback stage (`en`, `sel`) and the register file write-enable inputs (`m`).

---
 rtl/reg_write_decoder.sv | 90 +++++++++
 tb/tb_reg_write_decoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_decoder.sv
// Registered one-hot write-enable decoder for the register file write port,
// with a self-timed sweep that strobes every register once for clearing.
module reg_write_decoder #(
    parameter int SEL_W = 5,
    parameter bit PROTECT_ZERO = 1'b1,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    input  logic             clr_start,
    output logic [OUT_W-1:0] m,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    localparam logic [SEL_W-1:0] LAST = SEL_W'(OUT_W - 1);

    state_t           state;
    state_t           state_n;
    logic [SEL_W-1:0] cnt;
    logic [SEL_W-1:0] cnt_n;
    logic [OUT_W-1:0] m_n;
    logic             busy_n;
    logic             done_n;

    // Register 0 may be hardwired to zero, so its strobe is suppressed here.
    function automatic logic [OUT_W-1:0] strobe(input logic [SEL_W-1:0] i);
        logic [OUT_W-1:0] v;
        v = OUT_W'(1) << i;
        if (PROTECT_ZERO) v[0] = 1'b0;
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            m     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            m     <= m_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        m_n     = '0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (clr_start) begin
                    state_n = SCAN;
                    cnt_n   = SEL_W'(1);
                    m_n     = strobe('0);
                    busy_n  = 1'b1;
                end else if (en) begin
                    m_n = strobe(sel);
                end
            end
            SCAN: begin
                m_n = strobe(cnt);
                // The final strobe leaves busy low so a new request can land next edge.
                if (cnt == LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n  = cnt + SEL_W'(1);
                    busy_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_write_decoder.sv
// Bench for reg_write_decoder: four parameter sets share one stimulus stream
// and are checked every cycle against a strobe-position reference model.
module tb_reg_write_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [5:0] sel = '0;
    logic       clr_start = 1'b0;

    logic [31:0] m0;
    logic [31:0] m1;
    logic [1:0]  m2;
    logic [63:0] m3;
    logic [3:0]  bz;
    logic [3:0]  dn;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_write_decoder #(.SEL_W(5), .PROTECT_ZERO(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel[4:0]),
        .clr_start(clr_start), .m(m0), .busy(bz[0]), .done(dn[0]));
    reg_write_decoder #(.SEL_W(5), .PROTECT_ZERO(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel[4:0]),
        .clr_start(clr_start), .m(m1), .busy(bz[1]), .done(dn[1]));
    reg_write_decoder #(.SEL_W(1), .PROTECT_ZERO(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel[0:0]),
        .clr_start(clr_start), .m(m2), .busy(bz[2]), .done(dn[2]));
    reg_write_decoder #(.SEL_W(6), .PROTECT_ZERO(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel),
        .clr_start(clr_start), .m(m3), .busy(bz[3]), .done(dn[3]));

    int ow[4] = '{32, 32, 2, 64};
    bit pz[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    logic [63:0] am[4];
    assign am[0] = {32'd0, m0};
    assign am[1] = {32'd0, m1};
    assign am[2] = {62'd0, m2};
    assign am[3] = m3;

    // Model: pos is the index of the sweep strobe on m this cycle, -1 if none.
    int          pos[4];
    logic [63:0] em[4];
    logic        eb[4];
    logic        ed[4];

    function automatic int npos(int p, int o, logic c);
        if (p >= 0 && p < o - 1) return p + 1;
        if (c) return 0;
        return -1;
    endfunction

    function automatic logic [63:0] xm(int p, int c, logic e, int s);
        logic [63:0] v;
        if (p >= 0) v = 64'd1 << p;
        else if (e) v = 64'd1 << (s % ow[c]);
        else v = '0;
        if (pz[c]) v[0] = 1'b0;
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int c = 0; c < 4; c++) begin
            if (!rst_n) begin
                pos[c] <= -1;
                em[c]  <= '0;
                eb[c]  <= 1'b0;
                ed[c]  <= 1'b0;
            end else begin
                pos[c] <= npos(pos[c], ow[c], clr_start);
                em[c]  <= xm(npos(pos[c], ow[c], clr_start), c, en, int'(sel));
                eb[c]  <= npos(pos[c], ow[c], clr_start) >= 0 &&
                          npos(pos[c], ow[c], clr_start) < ow[c] - 1;
                ed[c]  <= npos(pos[c], ow[c], clr_start) == ow[c] - 1;
            end
        end
    end

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("m[%0d]", c), am[c], em[c]);
            chk($sformatf("busy[%0d]", c), 64'(bz[c]), 64'(eb[c]));
            chk($sformatf("done[%0d]", c), 64'(dn[c]), 64'(ed[c]));
            chk($sformatf("onehot[%0d]", c), 64'($onehot0(am[c])), 64'd1);
            if (pz[c]) chk($sformatf("bit0[%0d]", c), 64'(am[c][0]), 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int strobes;
    int dones;

    initial begin
        en = 1'b1;
        sel = 6'd5;
        repeat (3) begin
            step();
            chk("rst_m", 64'(m0), 64'd0);
            chk("rst_busy", 64'(bz[0]), 64'd0);
            chk("rst_done", 64'(dn[0]), 64'd0);
        end
        rst_n = 1'b1;
        step();
        chk("post_rst_m", 64'(m0), 64'h20);

        for (int s = 0; s < 64; s++) begin
            sel = 6'(s);
            step();
            if (s == 0) begin
                chk("dec0_prot", 64'(m0), 64'd0);
                chk("dec0_unprot", 64'(m1), 64'd1);
            end
            if (s == 1) chk("dec1", 64'(m0), 64'h2);
            if (s == 31) chk("dec31", 64'(m0), 64'h8000_0000);
            if (s == 63) chk("dec63", m3, 64'h8000_0000_0000_0000);
        end
        en = 1'b0;
        step();
        chk("dec_off", 64'(m0), 64'd0);

        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        chk("sw_first", 64'(m1), 64'h1);
        chk("sw_first_p", 64'(m0), 64'h0);
        chk("sw_busy", 64'(bz[0]), 64'd1);
        chk("sw_w1_a", 64'(m2), 64'h1);
        step();
        chk("sw_w1_b", 64'(m2), 64'h2);
        chk("sw_w1_done", 64'(dn[2]), 64'd1);
        repeat (30) step();
        chk("sw_last", 64'(m0), 64'h8000_0000);
        chk("sw_done", 64'(dn[0]), 64'd1);
        chk("sw_last_busy", 64'(bz[0]), 64'd0);
        step();
        chk("sw_after", 64'(m0), 64'd0);
        repeat (31) step();
        chk("sw63", m3, 64'h8000_0000_0000_0000);
        repeat (3) step();

        clr_start = 1'b1;
        en = 1'b1;
        sel = 6'd7;
        strobes = 0;
        dones = 0;
        step();
        clr_start = 1'b0;
        en = 1'b0;
        chk("prio_m", 64'(m0), 64'd0);
        chk("prio_m1", 64'(m1), 64'd1);
        for (int i = 0; i < 40; i++) begin
            if (m1 != 0) strobes++;
            if (dn[1]) dones++;
            en = (i >= 4 && i < 9);
            clr_start = (i >= 4 && i < 9);
            sel = 6'd3;
            step();
        end
        chk("ign_strobes", 64'(strobes), 64'd32);
        chk("ign_dones", 64'(dones), 64'd1);
        en = 1'b0;
        clr_start = 1'b0;
        repeat (70) step();

        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (10) step();
        chk("mid_m10", 64'(m1), 64'h400);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m", 64'(m0), 64'd0);
        chk("mid_rst_m3", m3, 64'd0);
        chk("mid_rst_busy", 64'(bz[0]), 64'd0);
        chk("mid_rst_done", 64'(dn[0]), 64'd0);
        step();
        rst_n = 1'b1;
        en = 1'b1;
        sel = 6'd2;
        step();
        chk("mid_rst_dec", 64'(m0), 64'h4);
        en = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            en = $urandom_range(1, 0) == 1;
            sel = 6'($urandom_range(63, 0));
            clr_start = $urandom_range(19, 0) == 0;
            rst_n = $urandom_range(499, 0) != 0;
            step();
        end
        rst_n = 1'b1;
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
